// File: rtl/uart_mm_peripheral.sv
// Memory-mapped 8N1 UART: TXDATA, RXDATA, STATUS, BAUDDIV and CTRL at word offsets 0-4,
// with one transmitter and one receiver sharing a programmable cycles-per-bit divider.
module uart_mm_peripheral #(
  parameter int DEFAULT_BAUDDIV = 434,
  parameter int MIN_BAUDDIV     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Select,
  input  logic        Write,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        tx,
  input  logic        rx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  function automatic logic [15:0] sat_div(input logic [15:0] d);
    logic [15:0] r;
    r = (d < 16'(MIN_BAUDDIV)) ? 16'(MIN_BAUDDIV) : d;
    return r;
  endfunction

  logic [2:0]  off;
  logic        wr_ev, rd_ev;
  logic        wr_txdata, wr_status, wr_baud, wr_ctrl, rd_rxdata;
  logic [7:0]  txdata, rxdata;
  logic [15:0] bauddiv;
  logic        rx_en, rx_valid, rx_overrun, frame_err, tx_busy;
  logic        unused_bits;

  assign off       = Addr[2:0];
  assign wr_ev     = Select & Write;
  assign rd_ev     = Select & ~Write;
  assign wr_txdata = wr_ev && (off == 3'd0);
  assign wr_status = wr_ev && (off == 3'd2);
  assign wr_baud   = wr_ev && (off == 3'd3);
  assign wr_ctrl   = wr_ev && (off == 3'd4);
  assign rd_rxdata = rd_ev && (off == 3'd1);
  assign unused_bits = ^{Addr[31:3], DataIn[31:16]};

  // ---------------- transmitter ----------------
  uart_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick;

  assign tx_tick = (tx_cnt == tx_div - 16'd1);
  assign tx_busy = (tx_state != IDLE);
  assign tx      = (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_shift[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) tx_state <= IDLE;
    else     tx_state <= tx_state_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    case (tx_state)
      IDLE:    if (wr_txdata) tx_state_n = START;
      START:   if (tx_tick) tx_state_n = DATA;
      DATA:    if (tx_tick && (tx_bit == 3'd7)) tx_state_n = STOP;
      STOP:    if (tx_tick) tx_state_n = IDLE;
      default: tx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt <= 16'd0;
      tx_bit <= 3'd0;
      tx_div <= 16'(DEFAULT_BAUDDIV);
    end else if (tx_state == IDLE) begin
      tx_cnt <= 16'd0;
      tx_bit <= 3'd0;
      if (wr_txdata) tx_div <= bauddiv;
    end else if (tx_tick) begin
      tx_cnt <= 16'd0;
      if (tx_state == DATA) tx_bit <= tx_bit + 3'd1;
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_state == IDLE && wr_txdata) tx_shift <= DataIn[7:0];
    else if (tx_state == DATA && tx_tick) tx_shift <= tx_shift >> 1;
  end

  // ---------------- receiver: rx_p0/rx_p1 synchronize, rx_p2 holds the previous sample ----------------
  logic        rx_p0, rx_p1, rx_p2;
  uart_state_t rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick, rx_half, rx_fall, rx_deliver;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_tick    = (rx_cnt == rx_div - 16'd1);
  assign rx_half    = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign rx_fall    = rx_p2 & ~rx_p1;
  assign rx_deliver = (rx_state == STOP) && rx_tick;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= IDLE;
    else     rx_state <= rx_state_n;
  end

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      IDLE:    if (rx_en && rx_fall) rx_state_n = START;
      START:   if (rx_half) rx_state_n = rx_p1 ? IDLE : DATA;
      DATA:    if (rx_tick && (rx_bit == 3'd7)) rx_state_n = STOP;
      STOP:    if (rx_tick) rx_state_n = IDLE;
      default: rx_state_n = IDLE;
    endcase
  end

  // Divider is re-captured every idle cycle, so it holds the value seen at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt <= 16'd0;
      rx_bit <= 3'd0;
      rx_div <= 16'(DEFAULT_BAUDDIV);
    end else if (rx_state == IDLE) begin
      rx_cnt <= 16'd0;
      rx_bit <= 3'd0;
      rx_div <= bauddiv;
    end else if ((rx_state == START) ? rx_half : rx_tick) begin
      rx_cnt <= 16'd0;
      if (rx_state == DATA) rx_bit <= rx_bit + 3'd1;
    end else begin
      rx_cnt <= rx_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == DATA && rx_tick) rx_shift <= {rx_p1, rx_shift[7:1]};
  end

  // ---------------- register file; error set wins over a coincident W1C ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      txdata     <= 8'd0;
      rxdata     <= 8'd0;
      bauddiv    <= 16'(DEFAULT_BAUDDIV);
      rx_en      <= 1'b1;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (wr_txdata && !tx_busy) txdata <= DataIn[7:0];
      if (wr_baud) bauddiv <= sat_div(DataIn[15:0]);
      if (wr_ctrl) rx_en <= DataIn[0];
      if (rx_deliver && (!rx_valid || rd_rxdata)) begin
        rxdata   <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_rxdata) begin
        rx_valid <= 1'b0;
      end
      if (rx_deliver && rx_valid && !rd_rxdata) rx_overrun <= 1'b1;
      else if (wr_status && DataIn[2])          rx_overrun <= 1'b0;
      if (rx_deliver && !rx_p1)                 frame_err <= 1'b1;
      else if (wr_status && DataIn[3])          frame_err <= 1'b0;
    end
  end

  always_comb begin
    DataOut = 32'd0;
    case (off)
      3'd0:    DataOut = {24'd0, txdata};
      3'd1:    DataOut = {24'd0, rxdata};
      3'd2:    DataOut = {28'd0, frame_err, rx_overrun, rx_valid, tx_busy};
      3'd3:    DataOut = {16'd0, bauddiv};
      3'd4:    DataOut = {31'd0, rx_en};
      default: DataOut = 32'd0;
    endcase
  end

endmodule
